// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request-classification helpers for the
// load/store unit memory-access controller.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ACCESS   = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
  function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
    if (store) return (f3 > F3_W);
    return (f3 == 3'd3) || (f3 > F3_HU);
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return (lo != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word from a bus read word and sign- or
// zero-extends it according to the load funct3.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            byte_off,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata[{byte_off, 3'b000} +: 8];
    sel_half = rdata[{byte_off[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    result = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
      F3_BU:   result = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
      F3_H:    result = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
      F3_HU:   result = {{(DATA_WIDTH-16){1'b0}}, sel_half};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding RV32I load/store controller: validates the request, issues
// one word-aligned bus access with strobes, waits for read data with a timeout.
//
// Handshakes: a request transfers on a rising CLK edge where req_valid && req_ready;
// req_ready is high only in IDLE. resp_valid is a one-cycle pulse that writeback
// always accepts. lsu_mem_en is a one-cycle pulse; loads complete on the first
// lsu_mem_rvld seen while waiting, stores are posted.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  resp_valid,
  output logic                  resp_we,
  output logic [4:0]            resp_rd,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  lsu_mem_en,
  output logic [ADDR_WIDTH-1:0] lsu_mem_addr,
  output logic [DATA_WIDTH-1:0] lsu_mem_wdata,
  output logic [STRB_WIDTH-1:0] lsu_mem_wen,
  input  logic [DATA_WIDTH-1:0] lsu_mem_rdata,
  input  logic                  lsu_mem_rvld,
  output logic [1:0]            state_dbg
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  lsu_state_e state, state_nx;

  logic                  cap_store;
  logic [2:0]            cap_f3;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [4:0]            cap_rd;
  logic [CW-1:0]         cnt;
  logic [1:0]            err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] align_result;
  logic                  req_illegal;
  logic                  req_misalign;

  assign req_illegal  = f3_illegal(req_store, req_funct3);
  assign req_misalign = addr_misaligned(req_funct3, req_addr[1:0]);
  assign state_dbg    = state;

  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .rdata    (lsu_mem_rdata),
    .byte_off (cap_addr[1:0]),
    .funct3   (cap_f3),
    .result   (align_result)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = (req_illegal || req_misalign) ? RESP : ISSUE;
      ISSUE:   state_nx = cap_store ? RESP : WAIT;
      WAIT:    if (lsu_mem_rvld || (cnt == CNT_LAST)) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request capture, timeout counter and response payload.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cap_store <= 1'b0;
      cap_f3    <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_rd    <= '0;
      cnt       <= '0;
      err_q     <= ERR_OK;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_store <= req_store;
            cap_f3    <= req_funct3;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_rd    <= req_rd;
            cnt       <= '0;
            rdata_q   <= '0;
            if (req_illegal)       err_q <= ERR_ILLEGAL;
            else if (req_misalign) err_q <= ERR_MISALIGN;
            else                   err_q <= ERR_OK;
          end
        end
        WAIT: begin
          if (lsu_mem_rvld)           rdata_q <= align_result;
          else if (cnt == CNT_LAST)   err_q   <= ERR_ACCESS;
          else                        cnt     <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Bus side is driven only during the single ISSUE cycle.
  always_comb begin
    lsu_mem_en    = 1'b0;
    lsu_mem_addr  = '0;
    lsu_mem_wdata = '0;
    lsu_mem_wen   = '0;
    if (state == ISSUE) begin
      lsu_mem_en   = 1'b1;
      lsu_mem_addr = {cap_addr[ADDR_WIDTH-1:2], 2'b00};
      case (cap_f3)
        F3_B: begin
          lsu_mem_wdata = {4{cap_wdata[7:0]}};
          if (cap_store) lsu_mem_wen = STRB_WIDTH'(4'b0001 << cap_addr[1:0]);
        end
        F3_H: begin
          lsu_mem_wdata = {2{cap_wdata[15:0]}};
          if (cap_store) lsu_mem_wen = STRB_WIDTH'(4'b0011 << {cap_addr[1], 1'b0});
        end
        default: begin
          lsu_mem_wdata = cap_wdata;
          if (cap_store) lsu_mem_wen = '1;
        end
      endcase
    end
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = 1'b0;
    resp_we    = 1'b0;
    resp_rd    = '0;
    resp_rdata = '0;
    resp_err   = ERR_OK;
    if (state == RESP) begin
      resp_valid = 1'b1;
      resp_we    = !cap_store && (err_q == ERR_OK);
      resp_rd    = cap_rd;
      resp_rdata = rdata_q;
      resp_err   = err_q;
    end
  end

endmodule
